// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
//   Demand-actuated, round-robin traffic light controller for NUM_DIR
//   conflicting approaches. One approach is served at a time through
//   red -> red+amber -> green -> amber -> all-red clearance. All phase
//   durations are counted in timebase ticks (tick input), so the block is
//   independent of the clock rate.
//
//   Optional feature: define PED_CROSSING_EN to add a pedestrian walk phase
//   (ports ped_req / walk). In the default build (macro undefined) those
//   ports do not exist and the WALK phase is unreachable.
//
//   Outputs are Moore: lights/green_dir/phase/walk decode state registers
//   only; there is no combinational path from req, tick or ped_req.

module traffic_light_ctrl #(
    parameter int NUM_DIR      = 4,
    parameter int RA_TICKS     = 2,
    parameter int GREEN_MIN    = 5,
    parameter int AMBER_TICKS  = 3,
    parameter int ALLRED_TICKS = 2,
    parameter int WALK_TICKS   = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic [NUM_DIR-1:0]         req,
`ifdef PED_CROSSING_EN
    input  logic                       ped_req,
    output logic                       walk,
`endif
    output logic [3*NUM_DIR-1:0]       lights,
    output logic [$clog2(NUM_DIR)-1:0] green_dir,
    output logic [2:0]                 phase
);

    localparam int DW = $clog2(NUM_DIR);

    // Timer must hold the largest duration minus one; one spare bit on top.
    localparam int MAX_A = (RA_TICKS > GREEN_MIN) ? RA_TICKS : GREEN_MIN;
    localparam int MAX_B = (AMBER_TICKS > ALLRED_TICKS) ? AMBER_TICKS : ALLRED_TICKS;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_D = (MAX_C > WALK_TICKS) ? MAX_C : WALK_TICKS;
    localparam int TW    = $clog2(MAX_D) + 1;

    // Phase encoding doubles as the phase output value.
    localparam logic [2:0] S_ALL_RED   = 3'd0;
    localparam logic [2:0] S_RED_AMBER = 3'd1;
    localparam logic [2:0] S_GREEN     = 3'd2;
    localparam logic [2:0] S_AMBER     = 3'd3;
    localparam logic [2:0] S_WALK      = 3'd4;

    localparam logic [TW-1:0] T_AR    = TW'(ALLRED_TICKS - 1);
    localparam logic [TW-1:0] T_RA    = TW'(RA_TICKS - 1);
    localparam logic [TW-1:0] T_GREEN = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] T_AMBER = TW'(AMBER_TICKS - 1);
    localparam logic [TW-1:0] T_WALK  = TW'(WALK_TICKS - 1);

    localparam logic [NUM_DIR-1:0] ONE = {{(NUM_DIR-1){1'b0}}, 1'b1};

    logic [2:0]         state, state_nxt;
    logic [TW-1:0]      timer, timer_nxt;
    logic [DW-1:0]      cur, cur_nxt;
    logic [NUM_DIR-1:0] pend;
    logic [NUM_DIR-1:0] cur_mask;
    logic               other_pend;
    logic               compete;

`ifdef PED_CROSSING_EN
    logic ped_pend;
    logic last_walk, last_walk_nxt;
    logic walk_go;
`endif

    // Round-robin pick: first set bit at cur+1, cur+2, ... with cur itself last.
    function automatic logic [DW-1:0] rr_pick(input logic [NUM_DIR-1:0] p,
                                              input logic [DW-1:0]      c);
        logic [DW-1:0] sel;
        logic [DW-1:0] idx;
        sel = c;
        // Walk the search order backwards so the nearest candidate wins.
        for (int k = NUM_DIR; k >= 1; k--) begin
            idx = DW'((int'(c) + k) % NUM_DIR);
            if (p[idx]) sel = idx;
        end
        return sel;
    endfunction

    // Final timer value of each state; the timer saturates there.
    function automatic logic [TW-1:0] last_tick(input logic [2:0] s);
        case (s)
            S_RED_AMBER: last_tick = T_RA;
            S_GREEN:     last_tick = T_GREEN;
            S_AMBER:     last_tick = T_AMBER;
            S_WALK:      last_tick = T_WALK;
            default:     last_tick = T_AR;
        endcase
    endfunction

    // Light field of the selected approach for a given state.
    function automatic logic [2:0] sel_field(input logic [2:0] s);
        case (s)
            S_RED_AMBER: sel_field = 3'b110;
            S_GREEN:     sel_field = 3'b001;
            S_AMBER:     sel_field = 3'b010;
            default:     sel_field = 3'b100;
        endcase
    endfunction

    assign cur_mask   = ONE << cur;
    assign other_pend = |(pend & ~cur_mask);
`ifdef PED_CROSSING_EN
    assign compete    = other_pend | ped_pend;
`else
    assign compete    = other_pend;
`endif

    // Next-state, timer and selection logic; everything advances only on tick.
    always_comb begin
        logic leave;
        state_nxt = state;
        timer_nxt = timer;
        cur_nxt   = cur;
        leave     = 1'b0;
`ifdef PED_CROSSING_EN
        last_walk_nxt = last_walk;
        walk_go       = 1'b0;
`endif
        if (tick) begin
            case (state)
                S_ALL_RED: begin
                    if (timer >= T_AR) begin
`ifdef PED_CROSSING_EN
                        // Walk takes priority unless it was the last phase
                        // served and vehicles are waiting.
                        if (ped_pend && (!last_walk || (pend == '0))) begin
                            state_nxt = S_WALK;
                            walk_go   = 1'b1;
                            leave     = 1'b1;
                        end else if (pend != '0) begin
                            state_nxt     = S_RED_AMBER;
                            cur_nxt       = rr_pick(pend, cur);
                            last_walk_nxt = 1'b0;
                            leave         = 1'b1;
                        end
`else
                        if (pend != '0) begin
                            state_nxt = S_RED_AMBER;
                            cur_nxt   = rr_pick(pend, cur);
                            leave     = 1'b1;
                        end
`endif
                    end
                end
                S_RED_AMBER: begin
                    if (timer == T_RA) begin
                        state_nxt = S_GREEN;
                        leave     = 1'b1;
                    end
                end
                S_GREEN: begin
                    if ((timer >= T_GREEN) && compete) begin
                        state_nxt = S_AMBER;
                        leave     = 1'b1;
                    end
                end
                S_AMBER: begin
                    if (timer == T_AMBER) begin
                        state_nxt = S_ALL_RED;
                        leave     = 1'b1;
                    end
                end
`ifdef PED_CROSSING_EN
                S_WALK: begin
                    if (timer == T_WALK) begin
                        state_nxt     = S_ALL_RED;
                        last_walk_nxt = 1'b1;
                        leave         = 1'b1;
                    end
                end
`endif
                default: begin
                    state_nxt = S_ALL_RED;
                    leave     = 1'b1;
                end
            endcase

            if (leave) begin
                timer_nxt = '0;
            end else if (timer < last_tick(state)) begin
                timer_nxt = timer + TW'(1);
            end
        end
    end

    // State registers, demand latches and synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_ALL_RED;
            timer <= '0;
            cur   <= '0;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            cur   <= cur_nxt;
            // Demand for the approach currently green is discarded.
            pend  <= (pend | req) & ~((state == S_GREEN) ? cur_mask : '0);
        end
    end

`ifdef PED_CROSSING_EN
    // Pedestrian demand latch and walk-history flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ped_pend  <= 1'b0;
            last_walk <= 1'b0;
        end else begin
            ped_pend  <= (ped_pend | ped_req) & ~walk_go;
            last_walk <= last_walk_nxt;
        end
    end

    assign walk = (state == S_WALK);
`endif

    // Moore light decode: only the selected approach ever leaves red.
    always_comb begin
        lights = '0;
        for (int i = 0; i < NUM_DIR; i++) begin
            lights[3*i +: 3] = (i == int'(cur)) ? sel_field(state) : 3'b100;
        end
    end

    assign green_dir = cur;
    assign phase     = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl
//   Directed bench for traffic_light_ctrl with NUM_DIR=3, RA_TICKS=2,
//   GREEN_MIN=4, AMBER_TICKS=3, ALLRED_TICKS=1, WALK_TICKS=6. Expected
//   phase / green_dir / lights values are hand-derived per clock edge.
//   Pedestrian scenarios run only when PED_CROSSING_EN is defined.

module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [2:0] req;
    logic [8:0] lights;
    logic [1:0] green_dir;
    logic [2:0] phase;
`ifdef PED_CROSSING_EN
    logic       ped_req;
    logic       walk;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Light patterns: [8:6] approach 2, [5:3] approach 1, [2:0] approach 0.
    localparam logic [8:0] L_AR  = 9'b100_100_100;
    localparam logic [8:0] L_RA0 = 9'b100_100_110;
    localparam logic [8:0] L_G0  = 9'b100_100_001;
    localparam logic [8:0] L_A0  = 9'b100_100_010;
    localparam logic [8:0] L_RA1 = 9'b100_110_100;
    localparam logic [8:0] L_G1  = 9'b100_001_100;
    localparam logic [8:0] L_A1  = 9'b100_010_100;
    localparam logic [8:0] L_RA2 = 9'b110_100_100;
    localparam logic [8:0] L_G2  = 9'b001_100_100;
    localparam logic [8:0] L_A2  = 9'b010_100_100;

    traffic_light_ctrl #(
        .NUM_DIR     (3),
        .RA_TICKS    (2),
        .GREEN_MIN   (4),
        .AMBER_TICKS (3),
        .ALLRED_TICKS(1),
        .WALK_TICKS  (6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .req      (req),
`ifdef PED_CROSSING_EN
        .ped_req  (ped_req),
        .walk     (walk),
`endif
        .lights   (lights),
        .green_dir(green_dir),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock edge, then check all outputs against the expected cycle.
    task automatic exp_cyc(input string tag, input logic [2:0] ph, input logic [1:0] gd,
                           input logic [8:0] lt, input logic wk);
        step();
        check({tag, ".phase"}, 32'(phase), 32'(ph));
        check({tag, ".dir"}, 32'(green_dir), 32'(gd));
        check({tag, ".lights"}, 32'(lights), 32'(lt));
`ifdef PED_CROSSING_EN
        check({tag, ".walk"}, 32'(walk), 32'(wk));
`else
        check({tag, ".nowalk"}, 32'(phase == 3'd4), 32'(wk));
`endif
    endtask

    initial begin
        rst  = 1'b1;
        tick = 1'b1;
        req  = 3'b000;
`ifdef PED_CROSSING_EN
        ped_req = 1'b0;
`endif
        // Scenario 1: reset, then idle with no demand.
        exp_cyc("rst", 3'd0, 2'd0, L_AR, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) exp_cyc("idle", 3'd0, 2'd0, L_AR, 1'b0);

        // Scenario 2: one-cycle request on approach 1.
        req = 3'b010;
        exp_cyc("s2.latch", 3'd0, 2'd0, L_AR, 1'b0);
        req = 3'b000;
        exp_cyc("s2.ra", 3'd1, 2'd1, L_RA1, 1'b0);
        exp_cyc("s2.ra", 3'd1, 2'd1, L_RA1, 1'b0);
        for (int i = 0; i < 32; i++) exp_cyc("s2.green", 3'd2, 2'd1, L_G1, 1'b0);

        // Scenario 3: competing demand on approaches 0 and 2.
        req = 3'b101;
        exp_cyc("s3.latch", 3'd2, 2'd1, L_G1, 1'b0);
        req = 3'b000;
        for (int i = 0; i < 3; i++) exp_cyc("s3.amber1", 3'd3, 2'd1, L_A1, 1'b0);
        exp_cyc("s3.ar1", 3'd0, 2'd1, L_AR, 1'b0);
        for (int i = 0; i < 2; i++) exp_cyc("s3.ra2", 3'd1, 2'd2, L_RA2, 1'b0);
        for (int i = 0; i < 4; i++) exp_cyc("s3.green2", 3'd2, 2'd2, L_G2, 1'b0);
        for (int i = 0; i < 3; i++) exp_cyc("s3.amber2", 3'd3, 2'd2, L_A2, 1'b0);
        exp_cyc("s3.ar2", 3'd0, 2'd2, L_AR, 1'b0);
        for (int i = 0; i < 2; i++) exp_cyc("s3.ra0", 3'd1, 2'd0, L_RA0, 1'b0);
        for (int i = 0; i < 5; i++) exp_cyc("s3.green0", 3'd2, 2'd0, L_G0, 1'b0);

        // Scenario 4: tick stalls mid red+amber; demand for cur is checked last.
        rst = 1'b1;
        exp_cyc("s4.rst", 3'd0, 2'd0, L_AR, 1'b0);
        rst = 1'b0;
        req = 3'b001;
        exp_cyc("s4.latch", 3'd0, 2'd0, L_AR, 1'b0);
        req = 3'b000;
        exp_cyc("s4.ra", 3'd1, 2'd0, L_RA0, 1'b0);
        exp_cyc("s4.ra", 3'd1, 2'd0, L_RA0, 1'b0);
        // Set tick low only now so the stalled state has one tick left.
        tick = 1'b0;
        for (int i = 0; i < 50; i++) exp_cyc("s4.stall", 3'd1, 2'd0, L_RA0, 1'b0);
        tick = 1'b1;
        exp_cyc("s4.resume", 3'd2, 2'd0, L_G0, 1'b0);
        exp_cyc("s4.green", 3'd2, 2'd0, L_G0, 1'b0);

        // Scenario 5: reset during green with demand pending on approach 2.
        req = 3'b100;
        exp_cyc("s5.latch", 3'd2, 2'd0, L_G0, 1'b0);
        req = 3'b000;
        rst = 1'b1;
        exp_cyc("s5.rst", 3'd0, 2'd0, L_AR, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) exp_cyc("s5.idle", 3'd0, 2'd0, L_AR, 1'b0);

`ifdef PED_CROSSING_EN
        // Scenario 6: pedestrian demand during approach 1 green.
        req = 3'b010;
        exp_cyc("s6.latch", 3'd0, 2'd0, L_AR, 1'b0);
        req = 3'b000;
        for (int i = 0; i < 2; i++) exp_cyc("s6.ra1", 3'd1, 2'd1, L_RA1, 1'b0);
        for (int i = 0; i < 6; i++) exp_cyc("s6.green1", 3'd2, 2'd1, L_G1, 1'b0);
        ped_req = 1'b1;
        exp_cyc("s6.plat", 3'd2, 2'd1, L_G1, 1'b0);
        for (int i = 0; i < 3; i++) exp_cyc("s6.amber1", 3'd3, 2'd1, L_A1, 1'b0);
        exp_cyc("s6.ar", 3'd0, 2'd1, L_AR, 1'b0);
        exp_cyc("s6.walk", 3'd4, 2'd1, L_AR, 1'b1);
        // Scenario 6a: vehicle demand arrives during the walk.
        req = 3'b001;
        exp_cyc("s6a.walk", 3'd4, 2'd1, L_AR, 1'b1);
        req = 3'b000;
        for (int i = 0; i < 4; i++) exp_cyc("s6a.walk", 3'd4, 2'd1, L_AR, 1'b1);
        exp_cyc("s6a.ar", 3'd0, 2'd1, L_AR, 1'b0);
        for (int i = 0; i < 2; i++) exp_cyc("s6a.ra0", 3'd1, 2'd0, L_RA0, 1'b0);
        for (int i = 0; i < 4; i++) exp_cyc("s6a.green0", 3'd2, 2'd0, L_G0, 1'b0);
        for (int i = 0; i < 3; i++) exp_cyc("s6a.amber0", 3'd3, 2'd0, L_A0, 1'b0);
        exp_cyc("s6a.ar", 3'd0, 2'd0, L_AR, 1'b0);
        for (int i = 0; i < 6; i++) exp_cyc("s6a.walk", 3'd4, 2'd0, L_AR, 1'b1);
        // Scenario 6b: no vehicle demand, walk repeats.
        exp_cyc("s6b.ar", 3'd0, 2'd0, L_AR, 1'b0);
        for (int i = 0; i < 6; i++) exp_cyc("s6b.walk", 3'd4, 2'd0, L_AR, 1'b1);
        ped_req = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
